// File: rtl/nibble_serial_add_ctrl_pkg.sv
// Shared definitions for the nibble-serial add/subtract sequencer.
//   state_t  : controller FSM encoding
//   NIBBLE_W : width of the adder slice
//   idx_w()  : width of the nibble index counter for a given nibble count
package nibble_serial_add_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int NIBBLE_W = 4;

    // WIDTH >= 8 guarantees at least two nibbles, so this is never 0.
    function automatic int idx_w(input int nibbles);
        return $clog2(nibbles);
    endfunction

endpackage

// File: rtl/nibble_serial_add_ctrl_adder.sv
// Combinational 4-bit ripple-carry adder slice with carry-in.
//   a, b  : nibble operands
//   cin   : carry into bit 0
//   s     : nibble sum
//   cout  : carry out of bit 3
//   c_msb : carry into bit 3, used for signed overflow on the top nibble
module nibble_adder_cin (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] s,
    output logic       cout,
    output logic       c_msb
);

    logic [4:0] c;

    always_comb begin
        c    = '0;
        s    = '0;
        c[0] = cin;
        for (int i = 0; i < 4; i++) begin
            s[i]   = a[i] ^ b[i] ^ c[i];
            c[i+1] = (a[i] & b[i]) | (a[i] & c[i]) | (b[i] & c[i]);
        end
    end

    assign cout  = c[4];
    assign c_msb = c[3];

endmodule

// File: rtl/nibble_serial_add_ctrl.sv
// Nibble-serial WIDTH-bit adder/subtractor. One 4-bit slice processes a
// nibble per clock, LSB first, with the carry registered between nibbles.
//   clk, rst_n          : clock, asynchronous active-low reset
//   in_valid/in_ready   : operation handshake (op_a, op_b, sub)
//   sub                 : 0 = A+B, 1 = A-B
//   out_valid/out_ready : result handshake (result, carry_out, overflow)
//   carry_out           : final carry (1 = no borrow when subtracting)
//   overflow            : signed overflow of the full-width operation
// WIDTH must be a multiple of 4 and at least 8.
module nibble_serial_add_ctrl
    import nibble_serial_add_ctrl_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             carry_out,
    output logic             overflow
);

    localparam int NIBBLES = WIDTH / NIBBLE_W;
    localparam int IDX_W   = idx_w(NIBBLES);
    localparam logic [IDX_W-1:0] LAST = IDX_W'(NIBBLES - 1);

    state_t           state, state_nxt;
    logic [IDX_W-1:0] idx;
    logic             carry;
    logic [WIDTH-1:0] a_q, b_q;

    logic [3:0] a_nib, b_nib, s_nib;
    logic       cout, c_msb;

    assign a_nib = a_q[NIBBLE_W*int'(idx) +: NIBBLE_W];
    assign b_nib = b_q[NIBBLE_W*int'(idx) +: NIBBLE_W];

    nibble_adder_cin u_slice (
        .a     (a_nib),
        .b     (b_nib),
        .cin   (carry),
        .s     (s_nib),
        .cout  (cout),
        .c_msb (c_msb)
    );

    // Handshake outputs decode registered state only, so there is no
    // combinational path from in_valid or out_ready.
    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (in_valid)     state_nxt = RUN;
            RUN:     if (idx == LAST)  state_nxt = DONE;
            DONE:    if (out_ready)    state_nxt = IDLE;
            default:                   state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx       <= '0;
            carry     <= 1'b0;
            a_q       <= '0;
            b_q       <= '0;
            result    <= '0;
            carry_out <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    // Subtraction is A + ~B + 1: invert B here and seed
                    // the carry chain with the +1.
                    a_q   <= op_a;
                    b_q   <= sub ? ~op_b : op_b;
                    carry <= sub;
                    idx   <= '0;
                end
                RUN: begin
                    result[NIBBLE_W*int'(idx) +: NIBBLE_W] <= s_nib;
                    carry <= cout;
                    if (idx == LAST) begin
                        carry_out <= cout;
                        overflow  <= c_msb ^ cout;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_nibble_serial_add_ctrl.sv
module tb_nibble_serial_add_ctrl;

    localparam int WIDTH   = 16;
    localparam int NIBBLES = WIDTH / 4;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] op_a, op_b;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             carry_out;
    logic             overflow;

    int checks = 0;
    int errors = 0;

    nibble_serial_add_ctrl #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op_a      (op_a),
        .op_b      (op_b),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .carry_out (carry_out),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    // Advance one edge and sample 1ns after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drives one operation, waits (bounded) for the result, returns what was
    // observed and consumes it. No checking here.
    task automatic run_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                          input logic s, output logic [WIDTH-1:0] r,
                          output logic co, output logic ov, output int lat,
                          output bit timeout);
        int n;
        timeout  = 1'b0;
        op_a     = a;
        op_b     = b;
        sub      = s;
        in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 50) begin step(); n++; end
        step();                      // accept edge
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 50) begin step(); lat++; end
        if (!out_valid) timeout = 1'b1;
        r  = result;
        co = carry_out;
        ov = overflow;
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        op_a = '0; op_b = '0; sub = 1'b0;
        step(); step();
        checks++; if (in_ready !== 1'b1)  begin errors++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
        checks++; if (result !== 16'h0)   begin errors++; $display("FAIL reset_result got %h want 0000", result); end
        checks++; if (carry_out !== 1'b0) begin errors++; $display("FAIL reset_carry_out got %b want 0", carry_out); end
        checks++; if (overflow !== 1'b0)  begin errors++; $display("FAIL reset_overflow got %b want 0", overflow); end
        rst_n = 1'b1;
        step();
    endtask

    typedef struct {
        logic [WIDTH-1:0] a, b;
        logic             s;
        logic [WIDTH-1:0] r;
        logic             co, ov;
    } vec_t;

    task automatic test_arith();
        vec_t v[7];
        logic [WIDTH-1:0] r;
        logic co, ov;
        int lat;
        bit to;
        v[0] = '{16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0, 1'b0};
        v[1] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0};
        v[2] = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1};
        v[3] = '{16'h1234, 16'h0235, 1'b1, 16'h0FFF, 1'b1, 1'b0};
        v[4] = '{16'h0000, 16'h0001, 1'b1, 16'hFFFF, 1'b0, 1'b0};
        v[5] = '{16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1};
        v[6] = '{16'hABCD, 16'h1111, 1'b0, 16'hBCDE, 1'b0, 1'b0};
        for (int i = 0; i < 7; i++) begin
            run_op(v[i].a, v[i].b, v[i].s, r, co, ov, lat, to);
            checks++; if (to) begin errors++; $display("FAIL arith%0d_timeout out_valid never rose", i); end
            checks++; if (lat != NIBBLES) begin errors++; $display("FAIL arith%0d_latency got %0d want %0d", i, lat, NIBBLES); end
            checks++; if (r !== v[i].r) begin errors++; $display("FAIL arith%0d_result got %h want %h", i, r, v[i].r); end
            checks++; if (co !== v[i].co) begin errors++; $display("FAIL arith%0d_carry got %b want %b", i, co, v[i].co); end
            checks++; if (ov !== v[i].ov) begin errors++; $display("FAIL arith%0d_overflow got %b want %b", i, ov, v[i].ov); end
        end
    endtask

    task automatic test_backpressure();
        int n;
        op_a = 16'h1111; op_b = 16'h2222; sub = 1'b0; in_valid = 1'b1;
        step();                          // accepted (block is idle)
        op_a = 16'h0101; op_b = 16'h0101; // next op offered during RUN/DONE
        n = 0;
        while (!out_valid && n < 50) begin step(); n++; end
        checks++; if (!out_valid) begin errors++; $display("FAIL bp_timeout out_valid never rose"); end
        for (int i = 0; i < 10; i++) begin
            checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_valid%0d got %b want 1", i, out_valid); end
            checks++; if (result !== 16'h3333) begin errors++; $display("FAIL bp_result%0d got %h want 3333", i, result); end
            checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready%0d got %b want 0", i, in_ready); end
            step();
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        checks++; if (in_ready !== 1'b1)  begin errors++; $display("FAIL bp_release_in_ready got %b want 1", in_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_release_out_valid got %b want 0", out_valid); end
        step();                          // pending op now accepted
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 50) begin step(); n++; end
        checks++; if (result !== 16'h0202) begin errors++; $display("FAIL bp_next_result got %h want 0202", result); end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
    endtask

    task automatic test_back_to_back();
        int acc[2];
        int nacc = 0;
        logic [WIDTH-1:0] res[2];
        logic co[2], ov[2];
        int nres = 0;
        op_a = 16'h1234; op_b = 16'h4321; sub = 1'b0;
        in_valid = 1'b1; out_ready = 1'b1;
        for (int e = 0; e < 20; e++) begin
            bit will_accept;
            will_accept = in_ready && in_valid;
            step();
            if (will_accept && nacc < 2) begin
                acc[nacc] = e;
                nacc++;
                if (nacc == 1) begin op_a = 16'h9000; op_b = 16'h1000; sub = 1'b1; end
                else in_valid = 1'b0;
            end
            if (out_valid && nres < 2) begin
                res[nres] = result; co[nres] = carry_out; ov[nres] = overflow;
                nres++;
            end
        end
        in_valid = 1'b0; out_ready = 1'b0;
        checks++; if (nacc != 2 || nres != 2) begin errors++; $display("FAIL b2b_count accepts %0d results %0d want 2 2", nacc, nres); end
        else begin
            checks++; if (acc[1] - acc[0] != NIBBLES + 2) begin errors++; $display("FAIL b2b_interval got %0d want %0d", acc[1] - acc[0], NIBBLES + 2); end
            checks++; if (res[0] !== 16'h5555) begin errors++; $display("FAIL b2b_result0 got %h want 5555", res[0]); end
            checks++; if (co[0] !== 1'b0 || ov[0] !== 1'b0) begin errors++; $display("FAIL b2b_flags0 got %b%b want 00", co[0], ov[0]); end
            checks++; if (res[1] !== 16'h8000) begin errors++; $display("FAIL b2b_result1 got %h want 8000", res[1]); end
            checks++; if (co[1] !== 1'b1 || ov[1] !== 1'b0) begin errors++; $display("FAIL b2b_flags1 got %b%b want 10", co[1], ov[1]); end
        end
        step();
    endtask

    task automatic test_reset_mid_run();
        logic [WIDTH-1:0] r;
        logic co, ov;
        int lat;
        bit to;
        op_a = 16'h3333; op_b = 16'h3333; sub = 1'b0; in_valid = 1'b1;
        step();                          // accept
        in_valid = 1'b0;
        step(); step();                  // two nibbles written
        rst_n = 1'b0;
        #1;                              // no clock edge in between
        checks++; if (in_ready !== 1'b1)  begin errors++; $display("FAIL rst_run_in_ready got %b want 1", in_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_run_out_valid got %b want 0", out_valid); end
        checks++; if (result !== 16'h0)   begin errors++; $display("FAIL rst_run_result got %h want 0000", result); end
        checks++; if (carry_out !== 1'b0 || overflow !== 1'b0) begin errors++; $display("FAIL rst_run_flags got %b%b want 00", carry_out, overflow); end
        step();
        rst_n = 1'b1;
        step();
        run_op(16'h0001, 16'h0001, 1'b0, r, co, ov, lat, to);
        checks++; if (to) begin errors++; $display("FAIL rst_fresh_timeout out_valid never rose"); end
        checks++; if (r !== 16'h0002) begin errors++; $display("FAIL rst_fresh_result got %h want 0002", r); end
        checks++; if (co !== 1'b0 || ov !== 1'b0) begin errors++; $display("FAIL rst_fresh_flags got %b%b want 00", co, ov); end
    endtask

    initial begin
        test_reset();
        test_arith();
        test_backpressure();
        test_back_to_back();
        test_reset_mid_run();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
